ccff_shadow_chain: RTL and testbench
====================================

# ccff_shadow_chain

Parametrised configuration-chain segment for a tile that combines a connection block and its IO grid. It carries NUM_CHAINS independent ccff scan chains, each CHAIN_LEN bits deep, behind a committed shadow register, so the fabric sees only a complete configuration. While a new bitstream shifts in, the fabric keeps running on the last committed value. A commit handshake applies the new value atomically, with IO isolation forced low around the update.

## Interface
Parameters:
- NUM_CHAINS, 2, number of independent ccff chains (e.g. routing chain + IO chain)
- CHAIN_LEN, 64, bits per chain; legal range ≥2
- CNT_W, $clog2(CHAIN_LEN+1), width of the shift counter (derived)

Ports:
- prog_clk  in  1  configuration clock; the only clock
- pReset  in  1  reset; asynchronous, active-low
- ccff_head  in  NUM_CHAINS  serial data in, one bit per chain
- shift_en  in  1  shift all chains one position this cycle
- commit  in  1  request transfer of shift contents to the shadow register
- IO_ISOL_N  in  1  global IO isolation, active-low
- ccff_tail  out  NUM_CHAINS  serial data out, last stage of each chain
- cfg_out  out  NUM_CHAINS*CHAIN_LEN  committed configuration; chain c occupies bits [c*CHAIN_LEN +: CHAIN_LEN]
- IO_ISOL_N_out  out  1  isolation passed to IO pads, active-low
- shift_cnt  out  CNT_W  shifts since last commit or reset, saturating
- full  out  1  shift_cnt == CHAIN_LEN
- commit_done  out  1  one-cycle pulse when a commit completes
- cmd_err  out  1  one-cycle pulse on a rejected command

## Operation
- Shift stage per chain: on shift_en, sr[0]<=ccff_head[c] and sr[i]<=sr[i-1]. ccff_tail[c]=sr[CHAIN_LEN-1].
- FSM states: IDLE, FILL, FULL, ISO, APPLY.
- IDLE/FILL transitions:
  - IDLE goes to FILL on the first shift_en.
  - FILL goes to FULL when the counter reaches CHAIN_LEN.
- Counter:
  - Increments on each shift and saturates at CHAIN_LEN.
  - Further shifts in FULL still shift data through (chain pass-through) and state stays FULL.
- Commit accepted:
  - Condition: commit=1 with shift_en=0, in FULL.
  - Sequence: ISO, then APPLY, then IDLE.
- Commit rejected (cmd_err pulse, no state change):
  - commit=1 in IDLE or FILL.
  - commit=1 together with shift_en=1 in FULL; the shift is still performed.
- ISO/APPLY: shift_en and commit are ignored and each raises cmd_err. The shift stage is frozen.
- Isolation: IO_ISOL_N_out = IO_ISOL_N & iso_q. iso_q is a register that reads 0 from reset until the first commit completes, and reads 0 during ISO and APPLY.
- Reset (asynchronous, any state, including mid-shift or mid-commit) clears:
  - sr, cfg_out, shift_cnt, commit_done, cmd_err and iso_q to 0;
  - the FSM to IDLE;
  - therefore IO_ISOL_N_out=0 and ccff_tail=0.

## Timing
- Shift latency: head bit sampled at edge k appears on ccff_tail after edge k+CHAIN_LEN-1, given continuous shift_en.
- Commit sampled at edge T (state FULL):
  - T: state<=ISO, iso_q<=0.
  - T+1: cfg_out<=sr, state<=APPLY.
  - T+2: iso_q<=1, commit_done<=1, shift_cnt<=0, state<=IDLE.
- Result: IO_ISOL_N_out is low for exactly two cycles (T+1..T+2), and cfg_out changes only while isolation is low.
- shift_en is accepted again at edge T+3.
- All outputs are registered except IO_ISOL_N_out (AND of register and input) and ccff_tail (register bit).
- Reset deassertion: the first shift is taken at the first prog_clk edge with pReset high.

## Structure
- Package ccff_pkg:
  - FSM state enum (IDLE, FILL, FULL, ISO, APPLY);
  - the isolation-window length constant ISO_CYCLES=2.
- Sub-module ccff_shift_reg:
  - one chain: shift register, tail tap, shadow register with load strobe;
  - instantiated NUM_CHAINS times by a generate loop.
- Top level holds the FSM, counter, isolation register and error/done pulses.

## Test plan
All scenarios use NUM_CHAINS=2, CHAIN_LEN=8.
- Reset then idle: after pReset release, cfg_out=0, IO_ISOL_N_out=0 with IO_ISOL_N=1, shift_cnt=0, full=0.
- Fill and commit: shift 0xA5 into chain0 and 0x3C into chain1 (MSB first), 8 cycles, then full=1. Pulse commit, then:
  - IO_ISOL_N_out is low for 2 cycles;
  - cfg_out=16'h3CA5;
  - commit_done pulses at T+2;
  - shift_cnt=0;
  - IO_ISOL_N_out is high after.
- Early commit: after 5 shifts, commit gives a cmd_err pulse; state and cfg_out are unchanged; shift_cnt stays 5.
- Pass-through: shift 12 bits; shift_cnt saturates at 8, and ccff_tail matches the head bits delayed by 8 cycles.
- Simultaneous shift+commit in FULL: shift occurs and cmd_err pulses, with no isolation and no cfg_out change. A shift_en asserted during ISO is ignored and flagged by cmd_err.
- Reset mid-commit: assert pReset during APPLY. Outputs go to their reset values immediately, IO_ISOL_N_out stays low, and the prior cfg_out is lost (reads 0).

Source files
------------

// File: rtl/ccff_pkg.sv
// Shared types for the ccff shadow configuration chain.
//   ccff_state_e : sequencing states of the chain controller
//   ISO_CYCLES   : cycles that IO isolation is held low around a commit
package ccff_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_FULL  = 3'd2,
    ST_ISO   = 3'd3,
    ST_APPLY = 3'd4
  } ccff_state_e;

  localparam int ISO_CYCLES = 2;

endpackage

// File: rtl/ccff_shift_reg.sv
// One ccff chain: a serial shift stage plus a shadow register.
//   prog_clk, pReset : clock, async active-low reset
//   shift            : advance the chain one position (din enters at bit 0)
//   din              : serial data in
//   load             : copy the shift stage into the shadow register
//   tail             : last shift stage bit (serial out)
//   cfg              : shadow register contents (what the fabric sees)
module ccff_shift_reg #(
  parameter int LEN = 64
) (
  input  logic           prog_clk,
  input  logic           pReset,
  input  logic           shift,
  input  logic           din,
  input  logic           load,
  output logic           tail,
  output logic [LEN-1:0] cfg
);

  logic [LEN-1:0] sr_q, sr_d;
  logic [LEN-1:0] cfg_q, cfg_d;

  always_comb begin
    sr_d  = sr_q;
    cfg_d = cfg_q;
    if (shift) sr_d = {sr_q[LEN-2:0], din};
    if (load)  cfg_d = sr_q;
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      sr_q  <= '0;
      cfg_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cfg_q <= cfg_d;
    end
  end

  assign tail = sr_q[LEN-1];
  assign cfg  = cfg_q;

endmodule

// File: rtl/ccff_shadow_chain.sv
// Configuration-chain segment: NUM_CHAINS scan chains behind a committed
// shadow register, with an atomic commit wrapped in an IO isolation window.
//   prog_clk, pReset : clock, async active-low reset
//   ccff_head/tail   : serial in/out, one bit per chain
//   shift_en, commit : shift request, commit request
//   IO_ISOL_N        : global isolation in (active-low)
//   IO_ISOL_N_out    : isolation to pads = IO_ISOL_N & iso_q
//   cfg_out          : committed configuration, chain c at [c*CHAIN_LEN +: CHAIN_LEN]
//   shift_cnt, full  : shifts since last commit (saturating), full flag
//   commit_done      : pulse when a commit completes
//   cmd_err          : pulse on a rejected command
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | nothing shifted since reset / last commit
// ST_FILL  | shifting, fewer than CHAIN_LEN bits in
// ST_FULL  | CHAIN_LEN bits in, commit allowed; further shifts pass through
// ST_ISO   | isolation low, shadow load happens on the exit edge
// ST_APPLY | isolation low, shadow holds new value; returns to idle
module ccff_shadow_chain
  import ccff_pkg::*;
#(
  parameter int NUM_CHAINS = 2,
  parameter int CHAIN_LEN  = 64,
  parameter int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
  input  logic                            prog_clk,
  input  logic                            pReset,
  input  logic [NUM_CHAINS-1:0]           ccff_head,
  input  logic                            shift_en,
  input  logic                            commit,
  input  logic                            IO_ISOL_N,
  output logic [NUM_CHAINS-1:0]           ccff_tail,
  output logic [NUM_CHAINS*CHAIN_LEN-1:0] cfg_out,
  output logic                            IO_ISOL_N_out,
  output logic [CNT_W-1:0]                shift_cnt,
  output logic                            full,
  output logic                            commit_done,
  output logic                            cmd_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHAIN_LEN);

  ccff_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             iso_q, iso_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             shift_ok;
  logic             load;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    iso_d    = iso_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    shift_ok = 1'b0;
    load     = 1'b0;
    case (state_q)
      ST_IDLE, ST_FILL, ST_FULL: begin
        shift_ok = shift_en;
        if (shift_en && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
        if (state_q != ST_FULL && shift_en)
          state_d = (cnt_d == CNT_MAX) ? ST_FULL : ST_FILL;
        if (commit) begin
          // A commit racing a shift would capture a half-moved chain.
          if (state_q == ST_FULL && !shift_en) begin
            state_d = ST_ISO;
            iso_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ISO: begin
        err_d   = shift_en | commit;
        load    = 1'b1;
        state_d = ST_APPLY;
      end
      ST_APPLY: begin
        err_d   = shift_en | commit;
        iso_d   = 1'b1;
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    full_d = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      iso_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      iso_q   <= iso_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  for (genvar c = 0; c < NUM_CHAINS; c++) begin : g_chain
    ccff_shift_reg #(.LEN(CHAIN_LEN)) u_chain (
      .prog_clk (prog_clk),
      .pReset   (pReset),
      .shift    (shift_ok),
      .din      (ccff_head[c]),
      .load     (load),
      .tail     (ccff_tail[c]),
      .cfg      (cfg_out[c*CHAIN_LEN +: CHAIN_LEN])
    );
  end

  assign IO_ISOL_N_out = IO_ISOL_N & iso_q;
  assign shift_cnt     = cnt_q;
  assign full          = full_q;
  assign commit_done   = done_q;
  assign cmd_err       = err_q;

endmodule

// File: tb/tb_ccff_shadow_chain.sv
module tb_ccff_shadow_chain;
  import ccff_pkg::*;

  localparam int NC = 2;
  localparam int CL = 8;
  localparam int CW = $clog2(CL + 1);

  logic             prog_clk;
  logic             pReset;
  logic [NC-1:0]    ccff_head;
  logic             shift_en;
  logic             commit;
  logic             IO_ISOL_N;
  logic [NC-1:0]    ccff_tail;
  logic [NC*CL-1:0] cfg_out;
  logic             IO_ISOL_N_out;
  logic [CW-1:0]    shift_cnt;
  logic             full;
  logic             commit_done;
  logic             cmd_err;

  int checks = 0;
  int failures = 0;
  logic [1:0] hist[$];

  ccff_shadow_chain #(.NUM_CHAINS(NC), .CHAIN_LEN(CL)) dut (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .ccff_head     (ccff_head),
    .shift_en      (shift_en),
    .commit        (commit),
    .IO_ISOL_N     (IO_ISOL_N),
    .ccff_tail     (ccff_tail),
    .cfg_out       (cfg_out),
    .IO_ISOL_N_out (IO_ISOL_N_out),
    .shift_cnt     (shift_cnt),
    .full          (full),
    .commit_done   (commit_done),
    .cmd_err       (cmd_err)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  // Expected shift-stage contents from the history of accepted shifts.
  function automatic logic [15:0] model_sr();
    logic [15:0] r;
    int n;
    r = '0;
    n = hist.size();
    for (int i = 0; i < CL; i++) begin
      if (n - 1 - i >= 0) begin
        r[i]      = hist[n-1-i][0];
        r[CL + i] = hist[n-1-i][1];
      end
    end
    return r;
  endfunction

  task automatic do_shift(input logic [1:0] h, input logic cmt);
    logic [15:0] m;
    ccff_head = h;
    shift_en  = 1'b1;
    commit    = cmt;
    tick();
    shift_en  = 1'b0;
    commit    = 1'b0;
    hist.push_back(h);
    m = model_sr();
    chk("tail", 64'(ccff_tail), 64'({m[15], m[7]}));
  endtask

  logic [7:0]  c0, c1;
  logic [1:0]  early_v[5];
  logic [1:0]  pt_v[12];
  logic [1:0]  last_v[8];
  logic [15:0] exp_new;
  int          iso_low;
  int          exp_cnt;

  initial begin
    c0 = 8'hA5;
    c1 = 8'h3C;
    early_v = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b10};
    pt_v    = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b01,
                2'b00, 2'b10, 2'b01, 2'b11, 2'b10, 2'b00};
    last_v  = '{2'b11, 2'b00, 2'b01, 2'b10, 2'b10, 2'b01, 2'b11, 2'b00};

    pReset = 1'b0; shift_en = 1'b0; commit = 1'b0; ccff_head = '0; IO_ISOL_N = 1'b1;
    tick(); tick();
    pReset = 1'b1;
    tick();
    chk("rst_cfg", 64'(cfg_out), 64'h0);
    chk("rst_isol", 64'(IO_ISOL_N_out), 64'h0);
    chk("rst_cnt", 64'(shift_cnt), 64'h0);
    chk("rst_full", 64'(full), 64'h0);
    chk("rst_tail", 64'(ccff_tail), 64'h0);

    // Fill 0xA5 / 0x3C, MSB first
    for (int i = 7; i >= 0; i--) begin
      do_shift({c1[i], c0[i]}, 1'b0);
      if (i == 4) chk("fill_cnt4", 64'(shift_cnt), 64'd4);
    end
    chk("fill_full", 64'(full), 64'h1);
    chk("fill_cnt", 64'(shift_cnt), 64'd8);
    chk("fill_cfg_old", 64'(cfg_out), 64'h0);

    commit = 1'b1; tick(); commit = 1'b0;
    chk("c1_T_isol", 64'(IO_ISOL_N_out), 64'h0);
    chk("c1_T_cfg", 64'(cfg_out), 64'h0);
    tick();
    chk("c1_T1_cfg", 64'(cfg_out), 64'h3CA5);
    chk("c1_T1_isol", 64'(IO_ISOL_N_out), 64'h0);
    chk("c1_T1_done", 64'(commit_done), 64'h0);
    tick();
    chk("c1_T2_isol", 64'(IO_ISOL_N_out), 64'h1);
    chk("c1_T2_done", 64'(commit_done), 64'h1);
    chk("c1_T2_cnt", 64'(shift_cnt), 64'h0);
    chk("c1_T2_full", 64'(full), 64'h0);
    tick();
    chk("c1_T3_done", 64'(commit_done), 64'h0);
    chk("c1_T3_isol", 64'(IO_ISOL_N_out), 64'h1);

    // Early commit after 5 shifts
    for (int i = 0; i < 5; i++) do_shift(early_v[i], 1'b0);
    chk("early_cnt", 64'(shift_cnt), 64'd5);
    commit = 1'b1; tick(); commit = 1'b0;
    chk("early_err", 64'(cmd_err), 64'h1);
    chk("early_cnt_hold", 64'(shift_cnt), 64'd5);
    chk("early_cfg", 64'(cfg_out), 64'h3CA5);
    chk("early_isol", 64'(IO_ISOL_N_out), 64'h1);
    tick();
    chk("early_err_clr", 64'(cmd_err), 64'h0);

    // Pass-through: 12 more shifts, counter saturates
    for (int i = 0; i < 12; i++) begin
      do_shift(pt_v[i], 1'b0);
      exp_cnt = (6 + i > CL) ? CL : 6 + i;
      chk("pt_cnt", 64'(shift_cnt), 64'(exp_cnt));
    end
    chk("pt_full", 64'(full), 64'h1);

    // Shift + commit together in FULL: shift happens, commit rejected
    do_shift(2'b11, 1'b1);
    chk("sc_err", 64'(cmd_err), 64'h1);
    chk("sc_isol", 64'(IO_ISOL_N_out), 64'h1);
    chk("sc_cfg", 64'(cfg_out), 64'h3CA5);
    chk("sc_cnt", 64'(shift_cnt), 64'd8);
    tick();
    chk("sc_err_clr", 64'(cmd_err), 64'h0);

    // Clean commit with a shift attempt during ISO
    exp_new = model_sr();
    iso_low = 0;
    commit = 1'b1; tick(); commit = 1'b0;
    if (IO_ISOL_N_out == 1'b0) iso_low++;
    chk("c2_T_err", 64'(cmd_err), 64'h0);
    ccff_head = 2'b11; shift_en = 1'b1; tick(); shift_en = 1'b0;
    if (IO_ISOL_N_out == 1'b0) iso_low++;
    chk("c2_iso_err", 64'(cmd_err), 64'h1);
    chk("c2_cfg", 64'(cfg_out), 64'(exp_new));
    chk("c2_tail_frozen", 64'(ccff_tail), 64'({exp_new[15], exp_new[7]}));
    tick();
    if (IO_ISOL_N_out == 1'b0) iso_low++;
    chk("c2_iso_len", 64'(iso_low), 64'(ISO_CYCLES));
    chk("c2_done", 64'(commit_done), 64'h1);
    chk("c2_err_clr", 64'(cmd_err), 64'h0);
    chk("c2_cnt", 64'(shift_cnt), 64'h0);

    // Reset during APPLY
    for (int i = 0; i < 8; i++) do_shift(last_v[i], 1'b0);
    exp_new = model_sr();
    commit = 1'b1; tick(); commit = 1'b0;
    tick();
    chk("r_apply_cfg", 64'(cfg_out), 64'(exp_new));
    pReset = 1'b0;
    #2;
    hist.delete();
    chk("r_cfg", 64'(cfg_out), 64'h0);
    chk("r_isol", 64'(IO_ISOL_N_out), 64'h0);
    chk("r_cnt", 64'(shift_cnt), 64'h0);
    chk("r_full", 64'(full), 64'h0);
    chk("r_tail", 64'(ccff_tail), 64'h0);
    chk("r_done", 64'(commit_done), 64'h0);
    tick();
    pReset = 1'b1;
    tick();
    chk("r_post_isol", 64'(IO_ISOL_N_out), 64'h0);
    chk("r_post_done", 64'(commit_done), 64'h0);
    chk("r_post_cfg", 64'(cfg_out), 64'h0);
    commit = 1'b1; tick(); commit = 1'b0;
    chk("r_idle_err", 64'(cmd_err), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
